// File: rtl/alu_pipe_if.sv
// Handshake and data bundle between an ALU requester and alu_pipe.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
    logic [3:0]       control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             taken;
    logic             ovf;
    logic             illegal;

    modport master (
        output in_valid, r1, r2, control, out_ready,
        input  in_ready, out_valid, result, zero, taken, ovf, illegal
    );

    modport slave (
        input  in_valid, r1, r2, control, out_ready,
        output in_ready, out_valid, result, zero, taken, ovf, illegal
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, result flags and an
// iterative shift-add multiplier. Holds its result under backpressure.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1100;

    logic [1:0]       state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             taken_q, taken_d;
    logic             ovf_q, ovf_d;
    logic             illegal_q, illegal_d;

    logic             accept;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;
    logic             alu_taken;
    logic             alu_ovf;
    logic             alu_ill;
    logic             alu_branch;
    logic [WIDTH-1:0] mul_add;

    assign bus.in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.taken     = taken_q;
    assign bus.ovf       = ovf_q;
    assign bus.illegal   = illegal_q;

    // Single-cycle operation result and flags from the live input operands.
    always_comb begin
        alu_res    = '0;
        alu_taken  = 1'b0;
        alu_ovf    = 1'b0;
        alu_ill    = 1'b0;
        alu_branch = 1'b0;
        shamt      = bus.r2[SHW-1:0];
        sum        = bus.r1 + bus.r2;
        diff       = bus.r1 - bus.r2;
        case (bus.control)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.r1[WIDTH-1] == bus.r2[WIDTH-1]) && (sum[WIDTH-1] != bus.r1[WIDTH-1]);
            end
            OP_AND:  alu_res = bus.r1 & bus.r2;
            OP_OR:   alu_res = bus.r1 | bus.r2;
            OP_SLL:  alu_res = bus.r1 << shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.r1) < $signed(bus.r2)};
            OP_SRL:  alu_res = bus.r1 >> shamt;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (bus.r1[WIDTH-1] != bus.r2[WIDTH-1]) && (diff[WIDTH-1] != bus.r1[WIDTH-1]);
            end
            OP_XOR:  alu_res = bus.r1 ^ bus.r2;
            OP_BEQ: begin
                alu_branch = 1'b1;
                alu_taken  = (bus.r1 == bus.r2);
            end
            OP_BNE: begin
                alu_branch = 1'b1;
                alu_taken  = (bus.r1 != bus.r2);
            end
            OP_SRA:  alu_res = $signed(bus.r1) >>> shamt;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.r1 < bus.r2};
            OP_MUL:  alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
        alu_zero = (alu_res == '0) && !alu_branch && !alu_ill;
    end

    // One shift-add step: add the multiplicand when the current multiplier bit is set.
    always_comb begin
        mul_add = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Next-state: FSM, multiplier iteration and result/flag loading.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        result_d  = result_q;
        zero_d    = zero_q;
        taken_d   = taken_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        if (state_q == S_BUSY) begin
            acc_d    = mul_add;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == SHW'(WIDTH - 1)) begin
                cnt_d     = '0;
                result_d  = mul_add;
                zero_d    = (mul_add == '0);
                taken_d   = 1'b0;
                ovf_d     = 1'b0;
                illegal_d = 1'b0;
                state_d   = S_DONE;
            end
        end else if (accept) begin
            // Accepting from DONE reuses the IDLE load path, giving back-to-back issue.
            if (bus.control == OP_MUL) begin
                mcand_d  = bus.r1;
                mplier_d = bus.r2;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = S_BUSY;
            end else begin
                result_d  = alu_res;
                zero_d    = alu_zero;
                taken_d   = alu_taken;
                ovf_d     = alu_ovf;
                illegal_d = alu_ill;
                state_d   = S_DONE;
            end
        end else if ((state_q == S_DONE) && bus.out_ready) begin
            state_d = S_IDLE;
        end
    end

    // State registers; reset discards any in-flight multiply and clears the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            taken_q   <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            taken_q   <= taken_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
        end
    end
endmodule
